// File: rtl/exec_cond_writeback.sv
// Execute-stage condition check, NZCV+Q flag register and write-port sequencer for 32/64-bit results.
// Latency: strobes are combinational in the same cycle; flags update on the next edge; a long result takes 2 cycles.
// Backpressure: Stall is high during the low-word cycle of a long result, and upstream holds for the high-word cycle.
module exec_cond_writeback (
  input  logic        clk,
  input  logic        reset,
  input  logic        Valid,
  input  logic [3:0]  Cond,
  input  logic [4:0]  ALUFlags,
  input  logic [1:0]  FlagW,
  input  logic        QW,
  input  logic        ClrQ,
  input  logic        RegW,
  input  logic        MemW,
  input  logic        PCS,
  input  logic        Long,
  input  logic [31:0] Result,
  input  logic [31:0] HiResult,
  input  logic [3:0]  RdLo,
  input  logic [3:0]  RdHi,
  output logic [4:0]  Flags,
  output logic        CarryFlag,
  output logic        CondEx,
  output logic        RegWrite,
  output logic [3:0]  WA3,
  output logic [31:0] WD3,
  output logic        MemWrite,
  output logic        PCSrc,
  output logic        Stall
);

  typedef enum logic {IDLE, HI} state_t;

  state_t      state;
  logic [31:0] hi_data;
  logic [3:0]  hi_addr;
  logic        cond_ok;
  logic        exec;
  logic        flag_q, flag_n, flag_z, flag_c, flag_v;

  assign {flag_q, flag_n, flag_z, flag_c, flag_v} = Flags;
  assign CarryFlag = Flags[1];

  // Condition field evaluated against the registered flags
  always_comb begin
    cond_ok = 1'b0;
    unique case (Cond)
      4'b0000: cond_ok = flag_z;
      4'b0001: cond_ok = ~flag_z;
      4'b0010: cond_ok = flag_c;
      4'b0011: cond_ok = ~flag_c;
      4'b0100: cond_ok = flag_n;
      4'b0101: cond_ok = ~flag_n;
      4'b0110: cond_ok = flag_v;
      4'b0111: cond_ok = ~flag_v;
      4'b1000: cond_ok = flag_c & ~flag_z;
      4'b1001: cond_ok = ~flag_c | flag_z;
      4'b1010: cond_ok = (flag_n == flag_v);
      4'b1011: cond_ok = (flag_n != flag_v);
      4'b1100: cond_ok = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ok = flag_z | (flag_n != flag_v);
      4'b1110: cond_ok = 1'b1;
      4'b1111: cond_ok = 1'b0;
      default: cond_ok = 1'b0;
    endcase
  end

  // Qualified instruction; gated by reset so no strobe escapes while reset is held
  assign exec   = reset & Valid & cond_ok & (state == IDLE);
  assign CondEx = cond_ok & (state == IDLE);

  // Write-port and strobe mux: live instruction in IDLE, latched high word in HI
  always_comb begin
    RegWrite = 1'b0;
    WA3      = RdLo;
    WD3      = Result;
    MemWrite = 1'b0;
    PCSrc    = 1'b0;
    Stall    = 1'b0;
    if (state == HI) begin
      RegWrite = 1'b1;
      WA3      = hi_addr;
      WD3      = hi_data;
    end else begin
      RegWrite = exec & RegW;
      MemWrite = exec & MemW;
      PCSrc    = exec & PCS;
      Stall    = exec & RegW & Long;
    end
  end

  // Sequencer state and high-word latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      hi_data <= '0;
      hi_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (exec & RegW & Long) begin
            state   <= HI;
            hi_data <= HiResult;
            hi_addr <= RdHi;
          end
        end
        HI: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NZCV updates only for executed instructions; sticky Q set beats clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Flags <= 5'b0;
    end else begin
      if (exec & FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (exec & FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
      if (exec & QW & ALUFlags[4]) Flags[4] <= 1'b1;
      else if (ClrQ)               Flags[4] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_cond_writeback.sv
// Randomized plus directed bench for exec_cond_writeback with a queue-based scoreboard.
// Stimulus pushes expected per-cycle outputs; a negedge monitor pops and compares.
// The reference model tracks flags and a pending high-word write as plain variables.
module tb_exec_cond_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        Valid;
  logic [3:0]  Cond;
  logic [4:0]  ALUFlags;
  logic [1:0]  FlagW;
  logic        QW, ClrQ, RegW, MemW, PCS, Long;
  logic [31:0] Result, HiResult;
  logic [3:0]  RdLo, RdHi;
  logic [4:0]  Flags;
  logic        CarryFlag, CondEx, RegWrite, MemWrite, PCSrc, Stall;
  logic [3:0]  WA3;
  logic [31:0] WD3;

  always #5 clk = ~clk;

  exec_cond_writeback dut (
    .clk(clk), .reset(reset), .Valid(Valid), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .QW(QW), .ClrQ(ClrQ), .RegW(RegW), .MemW(MemW), .PCS(PCS),
    .Long(Long), .Result(Result), .HiResult(HiResult), .RdLo(RdLo), .RdHi(RdHi),
    .Flags(Flags), .CarryFlag(CarryFlag), .CondEx(CondEx), .RegWrite(RegWrite),
    .WA3(WA3), .WD3(WD3), .MemWrite(MemWrite), .PCSrc(PCSrc), .Stall(Stall)
  );

  typedef struct {
    bit        rst_n;
    bit        valid;
    bit [3:0]  cond;
    bit [4:0]  aluf;
    bit [1:0]  flagw;
    bit        qw, clrq, regw, memw, pcs, lng;
    bit [31:0] res, hires;
    bit [3:0]  rdlo, rdhi;
  } stim_t;

  typedef struct {
    bit        chk_ce;
    bit        ce;
    bit        rw;
    bit [3:0]  wa;
    bit [31:0] wd;
    bit        mw, pc, st;
    bit [4:0]  fl;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  // Reference model state
  bit        m_hi;
  bit [31:0] m_hd;
  bit [3:0]  m_ha;
  bit        mq, mn, mz, mc, mv;

  function automatic bit cond_pass(input bit [3:0] c, input bit n, input bit z,
                                   input bit cf, input bit v);
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{default: 0};
    s.rst_n = 1'b1;
    s.cond  = 4'b1110;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One cycle: drive inputs after the edge, predict outputs, advance the model
  task automatic step(input stim_t s);
    exp_t e;
    bit ok, ex;
    @(posedge clk);
    #1;
    reset = s.rst_n; Valid = s.valid; Cond = s.cond; ALUFlags = s.aluf; FlagW = s.flagw;
    QW = s.qw; ClrQ = s.clrq; RegW = s.regw; MemW = s.memw; PCS = s.pcs; Long = s.lng;
    Result = s.res; HiResult = s.hires; RdLo = s.rdlo; RdHi = s.rdhi;
    e = '{default: 0};
    if (!s.rst_n) begin
      m_hi = 0; m_hd = 0; m_ha = 0;
      {mq, mn, mz, mc, mv} = 5'b0;
      e.fl     = 5'b0;
      e.chk_ce = 1;
      e.ce     = cond_pass(s.cond, 0, 0, 0, 0);
    end else if (m_hi) begin
      e.fl = {mq, mn, mz, mc, mv};
      e.rw = 1; e.wa = m_ha; e.wd = m_hd;
      m_hi = 0;
      if (s.clrq) mq = 0;
    end else begin
      e.fl     = {mq, mn, mz, mc, mv};
      ok       = cond_pass(s.cond, mn, mz, mc, mv);
      ex       = s.valid && ok;
      e.chk_ce = 1;
      e.ce     = ok;
      e.rw     = ex && s.regw;
      e.wa     = s.rdlo;
      e.wd     = s.res;
      e.mw     = ex && s.memw;
      e.pc     = ex && s.pcs;
      e.st     = ex && s.regw && s.lng;
      if (ex && s.flagw[1]) begin mn = s.aluf[3]; mz = s.aluf[2]; end
      if (ex && s.flagw[0]) begin mc = s.aluf[1]; mv = s.aluf[0]; end
      if (ex && s.qw && s.aluf[4]) mq = 1;
      else if (s.clrq)             mq = 0;
      if (e.st) begin m_hi = 1; m_hd = s.hires; m_ha = s.rdhi; end
    end
    sb.push_back(e);
  endtask

  // Monitor: compare every presented cycle against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("Flags", {27'b0, Flags}, {27'b0, e.fl});
        chk("CarryFlag", {31'b0, CarryFlag}, {31'b0, e.fl[1]});
        if (e.chk_ce) chk("CondEx", {31'b0, CondEx}, {31'b0, e.ce});
        chk("RegWrite", {31'b0, RegWrite}, {31'b0, e.rw});
        if (e.rw) begin
          chk("WA3", {28'b0, WA3}, {28'b0, e.wa});
          chk("WD3", WD3, e.wd);
        end
        chk("MemWrite", {31'b0, MemWrite}, {31'b0, e.mw});
        chk("PCSrc", {31'b0, PCSrc}, {31'b0, e.pc});
        chk("Stall", {31'b0, Stall}, {31'b0, e.st});
      end
    end
  end

  initial begin
    stim_t s;
    reset = 0; Valid = 0; Cond = 0; ALUFlags = 0; FlagW = 0; QW = 0; ClrQ = 0;
    RegW = 0; MemW = 0; PCS = 0; Long = 0; Result = 0; HiResult = 0; RdLo = 0; RdHi = 0;
    m_hi = 0; m_hd = 0; m_ha = 0; {mq, mn, mz, mc, mv} = 5'b0;

    // Reset state
    s = nop(); s.rst_n = 0; s.valid = 1; s.regw = 1; s.memw = 1; s.pcs = 1;
    step(s); step(s);
    step(nop());

    // EQ with Z=1 then Z=0
    s = nop(); s.valid = 1; s.flagw = 2'b10; s.aluf = 5'b00100; step(s);
    s = nop(); s.valid = 1; s.cond = 4'b0000; s.regw = 1; s.res = 32'h1234; s.rdlo = 4'd3; step(s);
    s = nop(); s.valid = 1; s.flagw = 2'b10; s.aluf = 5'b00000; step(s);
    s = nop(); s.valid = 1; s.cond = 4'b0000; s.regw = 1; s.res = 32'h1234; s.rdlo = 4'd3; step(s);

    // Partial flag update, then a never-condition that must not update
    s = nop(); s.valid = 1; s.aluf = 5'b01111; s.flagw = 2'b10; step(s);
    s = nop(); s.valid = 1; s.cond = 4'b1111; s.aluf = 5'b10011; s.flagw = 2'b11; s.qw = 1; step(s);
    step(nop());

    // Long write, with changed inputs during the high-word cycle
    s = nop(); s.valid = 1; s.regw = 1; s.lng = 1; s.res = 32'hDEADBEEF; s.hires = 32'h1;
    s.rdlo = 4'd4; s.rdhi = 4'd5; step(s);
    s.res = 32'h55; s.hires = 32'h77; s.rdlo = 4'd9; s.rdhi = 4'd10; s.memw = 1; s.pcs = 1;
    s.flagw = 2'b11; s.aluf = 5'b11111; step(s);
    step(nop());

    // Long write with RdLo == RdHi, and Long without RegW
    s = nop(); s.valid = 1; s.regw = 1; s.lng = 1; s.res = 32'hA; s.hires = 32'hB;
    s.rdlo = 4'd7; s.rdhi = 4'd7; step(s); step(nop());
    s = nop(); s.valid = 1; s.lng = 1; s.memw = 1; step(s); step(nop());

    // Sticky Q
    s = nop(); s.valid = 1; s.qw = 1; s.aluf = 5'b10000; step(s);
    s = nop(); s.valid = 1; s.flagw = 2'b11; s.aluf = 5'b00000; step(s);
    s = nop(); s.valid = 1; s.qw = 1; s.aluf = 5'b10000; s.clrq = 1; step(s);
    s = nop(); s.clrq = 1; step(s);
    step(nop());

    // Reset asserted during the high-word cycle
    s = nop(); s.valid = 1; s.flagw = 2'b11; s.aluf = 5'b01111; step(s);
    s = nop(); s.valid = 1; s.regw = 1; s.lng = 1; s.res = 32'h11; s.hires = 32'h22;
    s.rdlo = 4'd1; s.rdhi = 4'd2; step(s);
    s.rst_n = 0; step(s);
    step(nop());
    s = nop(); s.valid = 1; s.regw = 1; s.res = 32'h33; s.rdlo = 4'd6; step(s);

    // GE: N=1,V=1 passes; N=1,V=0 fails and suppresses strobes
    s = nop(); s.valid = 1; s.flagw = 2'b11; s.aluf = 5'b01001; step(s);
    s = nop(); s.valid = 1; s.cond = 4'b1010; s.memw = 1; s.pcs = 1; s.regw = 1; s.rdlo = 4'd8; s.res = 32'h44; step(s);
    s = nop(); s.valid = 1; s.flagw = 2'b11; s.aluf = 5'b01000; step(s);
    s = nop(); s.valid = 1; s.cond = 4'b1010; s.memw = 1; s.pcs = 1; step(s);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s.rst_n = ($urandom_range(0, 99) != 0);
      s.valid = ($urandom_range(0, 3) != 0);
      s.cond  = 4'($urandom_range(0, 15));
      s.aluf  = 5'($urandom_range(0, 31));
      s.flagw = 2'($urandom_range(0, 3));
      s.qw    = 1'($urandom_range(0, 1));
      s.clrq  = ($urandom_range(0, 7) == 0);
      s.regw  = 1'($urandom_range(0, 1));
      s.memw  = 1'($urandom_range(0, 1));
      s.pcs   = ($urandom_range(0, 3) == 0);
      s.lng   = ($urandom_range(0, 3) == 0);
      s.res   = $urandom;
      s.hires = $urandom;
      s.rdlo  = 4'($urandom_range(0, 15));
      s.rdhi  = 4'($urandom_range(0, 15));
      step(s);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
